// File: rtl/sbox_arbiter_if.sv
// Requester-side bundle for the shared S-box arbiter: the state (SubBytes) and key-word
// (SubWord) job channels plus the busy flag.
interface sbox_arbiter_if;
    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_din;
    logic [127:0] st_dout;
    logic         st_done;

    logic         kw_valid;
    logic         kw_ready;
    logic [31:0]  kw_din;
    logic [31:0]  kw_dout;
    logic         kw_done;

    logic         busy;

    modport master (
        output st_valid, st_din, kw_valid, kw_din,
        input  st_ready, st_dout, st_done, kw_ready, kw_dout, kw_done, busy
    );

    modport slave (
        input  st_valid, st_din, kw_valid, kw_din,
        output st_ready, st_dout, st_done, kw_ready, kw_dout, kw_done, busy
    );
endinterface

// File: rtl/sbox_arbiter.sv
// Round-robin shared pool of LANES registered AES S-boxes serving one 128-bit state job
// or one 32-bit key-word job at a time; bytes stream over 16/LANES or 4/LANES beats.
module sbox_arbiter #(
    parameter int LANES = 4
) (
    input logic           clk,
    input logic           rst,
    sbox_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    typedef enum logic {ST, KW} req_t;

    localparam logic [3:0] ST_LAST = 4'(16 / LANES - 1);
    localparam logic [3:0] KW_LAST = 4'(4 / LANES - 1);
    localparam logic [3:0] LANES_W = 4'(LANES);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 (the product a^2 * a^4 * ... * a^128), then the AES affine map.
    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] b;
        sq = a;
        b  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            b  = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    state_t       state;
    req_t         last_grant;
    req_t         job;
    logic [3:0]   beat;
    logic [3:0]   last_beat;
    logic [7:0]   job_buf  [16];
    logic [7:0]   res_buf  [16];
    logic [7:0]   res_next [16];
    logic [7:0]   lane_in  [LANES];
    logic         wr_en;
    logic [3:0]   wr_beat;
    logic         st_fire;
    logic         kw_fire;
    logic         st_done;
    logic         kw_done;
    logic         busy;
    logic [127:0] st_dout;
    logic [31:0]  kw_dout;

    // On a tie the requester that was not granted last gets the slot.
    assign bus.st_ready = ~rst & (state == IDLE) & (~bus.kw_valid | (last_grant == KW));
    assign bus.kw_ready = ~rst & (state == IDLE) & (~bus.st_valid | (last_grant == ST));
    assign st_fire      = bus.st_valid & bus.st_ready;
    assign kw_fire      = bus.kw_valid & bus.kw_ready;

    assign bus.st_done  = st_done;
    assign bus.kw_done  = kw_done;
    assign bus.st_dout  = st_dout;
    assign bus.kw_dout  = kw_dout;
    assign bus.busy     = busy;

    // NOTE: job_buf and res_buf are pure data storage, always fully rewritten before use, so they get no reset.
    always_ff @(posedge clk) begin
        if (st_fire) begin
            for (int i = 0; i < 16; i++) job_buf[i] <= bus.st_din[127 - 8*i -: 8];
        end else if (kw_fire) begin
            for (int i = 0; i < 4; i++) job_buf[i] <= bus.kw_din[31 - 8*i -: 8];
        end
        if (wr_en) begin
            for (int i = 0; i < 16; i++) res_buf[i] <= res_next[i];
        end
    end

    // S-box input registers; lane 0 carries the lowest byte index of the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < LANES; j++) lane_in[j] <= 8'h00;
            wr_en   <= 1'b0;
            wr_beat <= '0;
        end else begin
            wr_en   <= (state == ISSUE);
            wr_beat <= beat;
            for (int j = 0; j < LANES; j++) begin
                lane_in[j] <= (state == ISSUE) ? job_buf[beat * LANES_W + 4'(j)] : 8'h00;
            end
        end
    end

    // NOTE: every res_next entry is defaulted before the conditional writes, so no latch can form.
    always_comb begin
        for (int i = 0; i < 16; i++) res_next[i] = res_buf[i];
        if (wr_en) begin
            for (int j = 0; j < LANES; j++) begin
                res_next[wr_beat * LANES_W + 4'(j)] = sbox_byte(lane_in[j]);
            end
        end
    end

    // NOTE: all state here uses <= so each flop sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            last_beat  <= '0;
            last_grant <= ST;
            job        <= ST;
            st_done    <= 1'b0;
            kw_done    <= 1'b0;
            busy       <= 1'b0;
            st_dout    <= '0;
            kw_dout    <= '0;
        end else begin
            st_done <= 1'b0;
            kw_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (st_fire || kw_fire) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        beat       <= '0;
                        job        <= st_fire ? ST : KW;
                        last_grant <= st_fire ? ST : KW;
                        last_beat  <= st_fire ? ST_LAST : KW_LAST;
                    end
                end
                ISSUE: begin
                    if (beat == last_beat) state <= DRAIN;
                    else                   beat  <= beat + 4'd1;
                end
                DRAIN: begin
                    // The final beat lands in res_next this cycle, so the output is taken from it.
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (job == ST) begin
                        st_done <= 1'b1;
                        for (int i = 0; i < 16; i++) st_dout[127 - 8*i -: 8] <= res_next[i];
                    end else begin
                        kw_done <= 1'b1;
                        for (int i = 0; i < 4; i++) kw_dout[31 - 8*i -: 8] <= res_next[i];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_arbiter.sv
// Bench for sbox_arbiter: spec vectors, arbitration/reset sequences, LANES=1/2 builds and
// random traffic checked against a cycle-level reference model built from the AES field math.
module tb_sbox_arbiter;
    localparam int LANES = 4;

    typedef struct {
        bit           is_kw;
        logic [127:0] din;
        logic [127:0] want;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_arbiter_if bus ();
    sbox_arbiter_if bus2 ();
    sbox_arbiter_if bus1 ();

    sbox_arbiter #(.LANES(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    sbox_arbiter #(.LANES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    sbox_arbiter #(.LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [7:0]   sbox_tab [256];
    int           free_at;
    int           done_at;
    bit           done_kw;
    bit           lg_kw;
    logic [127:0] pend;
    logic [127:0] held_st;
    logic [31:0]  held_kw;
    bit           obs_st_done;
    bit           obs_kw_done;
    logic [127:0] obs_st_dout;
    int           obs_cyc;
    bit           acc_st;
    bit           acc_kw;
    int           acc_cyc;
    bit           dacc_st;
    bit           dacc_kw;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox_table();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_state(input logic [127:0] din);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_tab[din[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One cycle on the LANES=4 instance: registered outputs checked at entry, ready after inputs settle.
    task automatic step(input bit sv, input logic [127:0] sd, input bit kv, input logic [31:0] kd);
        bit exp_sd;
        bit exp_kd;
        bit idle;
        bit exp_sr;
        bit exp_kr;
        obs_cyc     = cyc;
        obs_st_done = bus.st_done;
        obs_kw_done = bus.kw_done;
        obs_st_dout = bus.st_dout;
        exp_sd = (cyc == done_at) && !done_kw;
        exp_kd = (cyc == done_at) && done_kw;
        if (exp_sd) held_st = pend;
        if (exp_kd) held_kw = pend[127:96];
        check("st_done", bus.st_done, exp_sd);
        check("kw_done", bus.kw_done, exp_kd);
        check("busy", bus.busy, cyc < free_at);
        check("st_dout", bus.st_dout, held_st);
        check("kw_dout", bus.kw_dout, held_kw);
        bus.st_valid = sv;
        bus.st_din   = sd;
        bus.kw_valid = kv;
        bus.kw_din   = kd;
        #1;
        idle   = (cyc >= free_at);
        exp_sr = idle && (!kv || lg_kw);
        exp_kr = idle && (!sv || !lg_kw);
        check("st_ready", bus.st_ready, exp_sr);
        check("kw_ready", bus.kw_ready, exp_kr);
        dacc_st = sv && bus.st_ready;
        dacc_kw = kv && bus.kw_ready;
        acc_st  = sv && exp_sr;
        acc_kw  = kv && exp_kr;
        if (acc_st || acc_kw) begin
            acc_cyc = cyc;
            lg_kw   = acc_kw;
            done_kw = acc_kw;
            done_at = cyc + (acc_kw ? 4 / LANES : 16 / LANES) + 2;
            free_at = done_at;
            pend    = acc_kw ? ref_state({kd, 96'h0}) : ref_state(sd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.st_valid  = 1'b0;
        bus.kw_valid  = 1'b0;
        bus2.st_valid = 1'b0;
        bus2.kw_valid = 1'b0;
        bus1.st_valid = 1'b0;
        bus1.kw_valid = 1'b0;
        #1;
        check("rst_st_ready", bus.st_ready, 1'b0);
        check("rst_kw_ready", bus.kw_ready, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 1; i < n; i++) begin
            check("rst_outputs", {bus.st_done, bus.kw_done, bus.busy, bus.st_ready, bus.kw_ready}, 5'b0);
            check("rst_st_dout", bus.st_dout, 128'h0);
            check("rst_kw_dout", bus.kw_dout, 32'h0);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        free_at = 0;
        done_at = -1;
        done_kw = 1'b0;
        lg_kw   = 1'b0;
        held_st = '0;
        held_kw = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int a;
        int lat;
        bit seen;
        lat  = -1;
        seen = 1'b0;
        step(!v.is_kw, v.din, v.is_kw, v.din[127:96]);
        a = acc_cyc;
        for (int k = 0; k < 30 && !seen; k++) begin
            step(1'b0, '0, 1'b0, '0);
            if (v.is_kw ? obs_kw_done : obs_st_done) begin
                seen = 1'b1;
                lat  = obs_cyc - a;
            end
        end
        check("vec_done_seen", seen, 1'b1);
        check("vec_latency", lat, v.lat);
        check("vec_dout", v.is_kw ? {bus.kw_dout, 96'h0} : bus.st_dout, v.want);
    endtask

    initial begin
        vec_t         vecs [6];
        bit           ord_kw [$];
        int           ord_c [$];
        int           acc_c [2];
        int           done_c [2];
        logic [127:0] douts [2];
        int           n_acc;
        int           n_done;
        int           a;
        int           lat1;
        int           lat2;
        int           n1;
        int           n2;
        bit           seen;

        vecs[0] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 6};
        vecs[1] = '{1'b1, {32'hcf4f3c09, 96'h0}, {32'h8a84eb01, 96'h0}, 3};
        vecs[2] = '{1'b0, {16{8'h00}}, {16{8'h63}}, 6};
        vecs[3] = '{1'b0, {16{8'hff}}, {16{8'h16}}, 6};
        vecs[4] = '{1'b0, {16{8'h53}}, {16{8'hed}}, 6};
        vecs[5] = '{1'b1, {32'h53535353, 96'h0}, {32'hedededed, 96'h0}, 3};

        bus.st_din  = '0;
        bus.kw_din  = '0;
        bus2.st_din = '0;
        bus2.kw_din = '0;
        bus1.st_din = '0;
        bus1.kw_din = '0;
        build_sbox_table();
        do_reset(3);

        // Narrow builds: state then word job on LANES=2 and LANES=1 in parallel.
        for (int p = 0; p < 2; p++) begin
            bus2.st_valid = (p == 0);
            bus1.st_valid = (p == 0);
            bus2.kw_valid = (p == 1);
            bus1.kw_valid = (p == 1);
            bus2.st_din = {16{8'h53}};
            bus1.st_din = {16{8'h53}};
            bus2.kw_din = 32'h53535353;
            bus1.kw_din = 32'h53535353;
            #1;
            check("l2_ready", (p == 0) ? bus2.st_ready : bus2.kw_ready, 1'b1);
            check("l1_ready", (p == 0) ? bus1.st_ready : bus1.kw_ready, 1'b1);
            a = cyc;
            @(posedge clk);
            #1;
            bus2.st_valid = 1'b0;
            bus1.st_valid = 1'b0;
            bus2.kw_valid = 1'b0;
            bus1.kw_valid = 1'b0;
            n1 = 0; n2 = 0; lat1 = -1; lat2 = -1;
            for (int k = 0; k < 30; k++) begin
                if ((p == 0) ? bus2.st_done : bus2.kw_done) begin n2++; lat2 = cyc - a; end
                if ((p == 0) ? bus1.st_done : bus1.kw_done) begin n1++; lat1 = cyc - a; end
                @(posedge clk);
                #1;
            end
            check("l2_done_count", n2, 1);
            check("l1_done_count", n1, 1);
            check("l2_latency", lat2, (p == 0) ? 10 : 4);
            check("l1_latency", lat1, (p == 0) ? 18 : 6);
            check("l2_dout", (p == 0) ? bus2.st_dout : {bus2.kw_dout, 96'h0},
                  (p == 0) ? {16{8'hed}} : {32'hedededed, 96'h0});
            check("l1_dout", (p == 0) ? bus1.st_dout : {bus1.kw_dout, 96'h0},
                  (p == 0) ? {16{8'hed}} : {32'hedededed, 96'h0});
        end

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            if (i == 1) check("word_keeps_st_dout", bus.st_dout, vecs[0].want);
        end

        // Tie straight after reset: KW, then ST in KW's done cycle, then KW again.
        do_reset(3);
        for (int k = 0; k < 40 && ord_kw.size() < 3; k++) begin
            step(1'b1, rand128(), 1'b1, $urandom());
            if (dacc_st || dacc_kw) begin
                ord_kw.push_back(dacc_kw);
                ord_c.push_back(obs_cyc);
            end
        end
        check("tie_accept_count", ord_kw.size(), 3);
        if (ord_kw.size() == 3) begin
            check("tie_first_kw", ord_kw[0], 1'b1);
            check("tie_second_st", ord_kw[1], 1'b0);
            check("tie_third_kw", ord_kw[2], 1'b1);
            check("tie_st_at_kw_done", ord_c[1] - ord_c[0], 3);
            check("tie_kw_at_st_done", ord_c[2] - ord_c[1], 6);
        end
        for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b0, '0);

        // Back-to-back state jobs with st_valid held high.
        n_acc = 0;
        n_done = 0;
        for (int k = 0; k < 40 && n_done < 2; k++) begin
            step(n_acc < 2, (n_acc == 0) ? {16{8'h00}} : {16{8'hff}}, 1'b0, '0);
            if (obs_st_done) begin
                done_c[n_done] = obs_cyc;
                douts[n_done]  = obs_st_dout;
                n_done++;
            end
            if (dacc_st && n_acc < 2) begin
                acc_c[n_acc] = obs_cyc;
                n_acc++;
            end
        end
        check("b2b_done_count", n_done, 2);
        if (n_done == 2) begin
            check("b2b_first_dout", douts[0], {16{8'h63}});
            check("b2b_second_dout", douts[1], {16{8'h16}});
            check("b2b_accept_at_done", acc_c[1], done_c[0]);
            check("b2b_second_latency", done_c[1] - acc_c[1], 6);
        end

        // Reset in cycle 3 of a state job aborts it without a done.
        step(1'b1, rand128(), 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        do_reset(3);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, '0, 1'b0, '0);
            if (obs_st_done) seen = 1'b1;
        end
        check("no_done_after_abort", seen, 1'b0);
        run_vec(vecs[2]);

        // Random traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset(2);
            else step(1'($urandom_range(0, 1)), rand128(), 1'($urandom_range(0, 1)), $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
